binupcnt_ctrl: RTL and testbench
================================

BINUPCNT_CTRL -- requirements
Module: binupcnt_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_BIT_WIDTH, default 4, which sets the count/limit width.
REQ-002 The block SHALL have parameter WRAP_BIT_WIDTH, default 8, which sets the wrap counter width.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level-sampled request to begin a count run.
REQ-006 stop  input  1  level-sampled abort; returns the block to idle.
REQ-007 pause  input  1  level; while high, RUN/HOLD count is frozen.
REQ-008 mode  input  1  0 = one-shot, 1 = continuous; sampled with start.
REQ-009 limit  input  CNT_BIT_WIDTH  terminal value; sampled with start.
REQ-010 q  output  CNT_BIT_WIDTH  current count, registered.
REQ-011 state  output  2  FSM state: IDLE=00, RUN=01, HOLD=10, DONE=11.
REQ-012 busy  output  1  high in RUN or HOLD.
REQ-013 done  output  1  registered one-cycle pulse on each terminal event.
REQ-014 wrap_cnt  output  WRAP_BIT_WIDTH  number of continuous-mode wraps since start, saturating.

Function
REQ-015 Event priority each cycle SHALL be stop > start > pause > count advance.
REQ-016 IDLE: q=0. On start && !stop, the block SHALL capture limit/mode into limit_r/mode_r, clear wrap_cnt, and move to RUN with q=0.
REQ-017 RUN, pause=0, q!=limit_r: q SHALL increment by 1 per cycle.
REQ-018 RUN, pause=1: the block SHALL go to HOLD and q SHALL NOT advance in that cycle.
REQ-019 HOLD: q SHALL hold; pause=0 SHALL return the block to RUN, and counting SHALL resume on the following cycle.
REQ-020 RUN, pause=0, q==limit_r, mode_r=0: the block SHALL go to DONE, q SHALL hold limit_r, and done SHALL be 1 for exactly the first DONE cycle.
REQ-021 RUN, pause=0, q==limit_r, mode_r=1: q SHALL go to 0, the block SHALL stay in RUN, done SHALL pulse 1 on the next cycle, and wrap_cnt SHALL increment, saturating at all-ones.
REQ-022 limit_r=0: one-shot mode SHALL reach DONE one cycle after entering RUN; continuous mode SHALL hold q=0 and wrap every RUN cycle.
REQ-023 q SHALL never exceed limit_r; there SHALL be no natural 2^CNT_BIT_WIDTH rollover when limit_r < max.
REQ-024 limit_r=all-ones in continuous mode SHALL wrap from 15 to 0, which counts as one wrap.
REQ-025 Changes on limit/mode outside the IDLE->RUN or DONE->RUN transitions SHALL be ignored.
REQ-026 start in RUN or HOLD SHALL be ignored (no restart).
REQ-027 DONE: the block SHALL hold until start (same capture as REQ-016, q=0) or stop.
REQ-028 stop in RUN, HOLD or DONE SHALL move the block to IDLE with q=0 and done=0 on the next cycle, and wrap_cnt SHALL hold its value until the next start.
REQ-029 start && stop asserted together SHALL act as stop.
REQ-030 Terminal condition && pause in the same cycle SHALL resolve as pause (go to HOLD; no wrap, no done).
REQ-031 busy SHALL be decoded from the state register, with no combinational path from the inputs.

Reset
REQ-032 While rst_n=0, regardless of clk, the block SHALL hold: state=IDLE, q=0, busy=0, done=0, wrap_cnt=0, limit_r=all-ones, mode_r=0.
REQ-033 Reset asserted mid-run SHALL force REQ-032 values immediately; after release the block SHALL stay in IDLE until start.
REQ-034 Reset release SHALL take effect on the first rising clk edge with rst_n=1.

Verification
REQ-035 Bench: 10 ns clk period, rst_n low for the first 10 ns; all outputs SHALL be at reset values and q=0 throughout.
REQ-036 One-shot: limit=5, mode=0, start for 1 cycle -> q=0,1,2,3,4,5; DONE with done pulse; q holds 5; busy falls on DONE entry.
REQ-037 Continuous: limit=3, mode=1, start, 10 cycles -> q=0,1,2,3,0,1,2,3,0,1; wrap_cnt=2; done pulses twice.
REQ-038 Pause: limit=9, one-shot, pause high at q=4 for 3 cycles -> state HOLD, q=4 frozen; resume gives q=5; DONE at 9.
REQ-039 Stop/simultaneous: stop during RUN at q=6 -> IDLE, q=0 next cycle; start+stop in IDLE -> stays IDLE; start during RUN -> no effect.
REQ-040 Edge cases: limit=0 one-shot -> DONE after 1 cycle; limit=15 continuous for 20 cycles -> 15->0 wrap, wrap_cnt=1; rst_n pulsed low at q=7 -> immediate q=0, IDLE.

Source files
------------

// File: rtl/binupcnt_ctrl.sv
// -----------------------------------------------------------------------------
// binupcnt_ctrl -- controlled binary up-counter with a small run FSM.
//
// A run starts on `start`, which captures `limit` and `mode`. The count goes
// from 0 up to the captured limit. In one-shot mode the block then parks in
// DONE. In continuous mode it wraps to 0 and counts the wrap in a saturating
// counter. `pause` freezes the count in HOLD, and `stop` aborts to IDLE.
// Priority each cycle: stop > start > pause > count advance.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   level-sampled run request (ignored in RUN/HOLD)
//   stop      in   level-sampled abort back to IDLE
//   pause     in   level; freezes the count (RUN -> HOLD)
//   mode      in   0 = one-shot, 1 = continuous; captured with start
//   limit     in   terminal count; captured with start
//   q         out  current count (registered)
//   state     out  IDLE=00, RUN=01, HOLD=10, DONE=11
//   busy      out  high in RUN or HOLD (decoded from the state register)
//   done      out  one-cycle registered pulse per terminal event
//   wrap_cnt  out  continuous-mode wraps since the last start, saturating
// -----------------------------------------------------------------------------
module binupcnt_ctrl #(
  parameter int CNT_BIT_WIDTH  = 4,
  parameter int WRAP_BIT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      pause,
  input  logic                      mode,
  input  logic [CNT_BIT_WIDTH-1:0]  limit,
  output logic [CNT_BIT_WIDTH-1:0]  q,
  output logic [1:0]                state,
  output logic                      busy,
  output logic                      done,
  output logic [WRAP_BIT_WIDTH-1:0] wrap_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  state_t                    r_state;
  logic [CNT_BIT_WIDTH-1:0]  r_q;
  logic [CNT_BIT_WIDTH-1:0]  r_limit;
  logic                      r_mode;
  logic                      r_done;
  logic [WRAP_BIT_WIDTH-1:0] r_wrap_cnt;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_q        <= '0;
      r_limit    <= '1;
      r_mode     <= 1'b0;
      r_done     <= 1'b0;
      r_wrap_cnt <= '0;
    end else begin
      // done is a pulse: cleared every cycle unless a terminal event sets it.
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_q <= '0;
          if (start && !stop) begin
            r_limit    <= limit;
            r_mode     <= mode;
            r_wrap_cnt <= '0;
            r_state    <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (stop) begin
            // wrap_cnt is deliberately kept so software can read it after an abort.
            r_q     <= '0;
            r_state <= ST_IDLE;
          end else if (pause) begin
            // Pause wins over a simultaneous terminal condition: no wrap, no done.
            r_state <= ST_HOLD;
          end else if (r_q == r_limit) begin
            r_done <= 1'b1;
            if (r_mode) begin
              r_q <= '0;
              if (r_wrap_cnt != '1) r_wrap_cnt <= r_wrap_cnt + 1'b1;
            end else begin
              r_state <= ST_DONE;
            end
          end else begin
            r_q <= r_q + 1'b1;
          end
        end

        ST_HOLD: begin
          if (stop) begin
            r_q     <= '0;
            r_state <= ST_IDLE;
          end else if (!pause) begin
            // Re-enter RUN with q unchanged; counting resumes the cycle after.
            r_state <= ST_RUN;
          end
        end

        ST_DONE: begin
          if (stop) begin
            r_q     <= '0;
            r_state <= ST_IDLE;
          end else if (start) begin
            r_limit    <= limit;
            r_mode     <= mode;
            r_wrap_cnt <= '0;
            r_q        <= '0;
            r_state    <= ST_RUN;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign q        = r_q;
  assign state    = r_state;
  assign busy     = (r_state == ST_RUN) || (r_state == ST_HOLD);
  assign done     = r_done;
  assign wrap_cnt = r_wrap_cnt;

endmodule

// File: tb/tb_binupcnt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_binupcnt_ctrl -- directed self-checking bench for binupcnt_ctrl.
// Inputs change 1 ns after a rising edge. Outputs are checked at that same
// point, before the new inputs are applied.
// -----------------------------------------------------------------------------
module tb_binupcnt_ctrl;

  localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10, DONE = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, pause, mode;
  logic [3:0] limit;
  logic [3:0] q;
  logic [1:0] state;
  logic       busy, done;
  logic [7:0] wrap_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  binupcnt_ctrl #(.CNT_BIT_WIDTH(4), .WRAP_BIT_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .mode     (mode),
    .limit    (limit),
    .q        (q),
    .state    (state),
    .busy     (busy),
    .done     (done),
    .wrap_cnt (wrap_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [1:0] e_state, input logic [3:0] e_q,
                           input logic e_done, input logic [7:0] e_wrap);
    check({tag, ".state"}, 32'(state), 32'(e_state));
    check({tag, ".q"}, 32'(q), 32'(e_q));
    check({tag, ".busy"}, 32'(busy), 32'(e_state == RUN || e_state == HOLD));
    check({tag, ".done"}, 32'(done), 32'(e_done));
    check({tag, ".wrap"}, 32'(wrap_cnt), 32'(e_wrap));
  endtask

  task automatic go(input logic [3:0] lim, input logic md);
    start = 1'b1; limit = lim; mode = md;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int done_seen;
    logic [3:0] cont_q [9] = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0; limit = 4'd0;
    #1 check_all("rst0", IDLE, 4'd0, 1'b0, 8'd0);
    start = 1'b1; limit = 4'd3;  // ignored while in reset
    #6 check_all("rst1", IDLE, 4'd0, 1'b0, 8'd0);
    start = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    check_all("post_rst", IDLE, 4'd0, 1'b0, 8'd0);

    // One-shot, limit 5.
    go(4'd5, 1'b0);
    check_all("os_start", RUN, 4'd0, 1'b0, 8'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("os_cnt.q", 32'(q), 32'(i));
    end
    tick();
    check_all("os_done", DONE, 4'd5, 1'b1, 8'd0);
    tick();
    check_all("os_hold", DONE, 4'd5, 1'b0, 8'd0);
    stop = 1'b1; tick(); stop = 1'b0;
    check_all("os_stop", IDLE, 4'd0, 1'b0, 8'd0);

    // Continuous, limit 3.
    go(4'd3, 1'b1);
    check_all("ct_start", RUN, 4'd0, 1'b0, 8'd0);
    done_seen = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("ct.q", 32'(q), 32'(cont_q[i]));
      if (done) done_seen++;
    end
    check("ct.wrap", 32'(wrap_cnt), 32'd2);
    check("ct.done_pulses", 32'(done_seen), 32'd2);
    stop = 1'b1; tick(); stop = 1'b0;
    check_all("ct_stop", IDLE, 4'd0, 1'b0, 8'd2);

    // Pause, limit 9, one-shot.
    go(4'd9, 1'b0);
    check("pz_start.wrap", 32'(wrap_cnt), 32'd0);
    repeat (4) tick();
    check("pz_q4", 32'(q), 32'd4);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("pz_hold", HOLD, 4'd4, 1'b0, 8'd0);
    end
    pause = 1'b0;
    tick();
    check_all("pz_resume", RUN, 4'd4, 1'b0, 8'd0);
    tick();
    check("pz_q5", 32'(q), 32'd5);
    repeat (4) tick();
    check("pz_q9", 32'(q), 32'd9);
    tick();
    check_all("pz_done", DONE, 4'd9, 1'b1, 8'd0);

    // Restart from DONE, ignored start in RUN, stop at 6.
    go(4'd9, 1'b0);
    check_all("rs_start", RUN, 4'd0, 1'b0, 8'd0);
    repeat (3) tick();
    start = 1'b1; limit = 4'd2; mode = 1'b1;
    tick();
    start = 1'b0;
    check_all("rs_ignore", RUN, 4'd4, 1'b0, 8'd0);
    repeat (2) tick();
    check("rs_q6", 32'(q), 32'd6);
    stop = 1'b1; tick();
    check_all("rs_stop", IDLE, 4'd0, 1'b0, 8'd0);
    start = 1'b1; tick();
    check_all("start_stop", IDLE, 4'd0, 1'b0, 8'd0);
    start = 1'b0; stop = 1'b0;

    // limit 0 one-shot.
    go(4'd0, 1'b0);
    check_all("l0os_start", RUN, 4'd0, 1'b0, 8'd0);
    tick();
    check_all("l0os_done", DONE, 4'd0, 1'b1, 8'd0);

    // limit 0 continuous: wraps every cycle, saturates at 255.
    go(4'd0, 1'b1);
    tick();
    check_all("l0ct_w1", RUN, 4'd0, 1'b1, 8'd1);
    repeat (299) tick();
    check_all("l0ct_sat", RUN, 4'd0, 1'b1, 8'd255);
    // Terminal condition and pause together: pause wins.
    pause = 1'b1; tick();
    check_all("term_pause", HOLD, 4'd0, 1'b0, 8'd255);
    pause = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
    check_all("l0ct_stop", IDLE, 4'd0, 1'b0, 8'd255);

    // limit 15 continuous, 20 cycles.
    go(4'd15, 1'b1);
    repeat (15) tick();
    check_all("l15_top", RUN, 4'd15, 1'b0, 8'd0);
    tick();
    check_all("l15_wrap", RUN, 4'd0, 1'b1, 8'd1);
    repeat (4) tick();
    check_all("l15_end", RUN, 4'd4, 1'b0, 8'd1);
    stop = 1'b1; tick(); stop = 1'b0;

    // Asynchronous reset mid-run.
    go(4'd9, 1'b0);
    repeat (7) tick();
    check("ar_q7", 32'(q), 32'd7);
    #2 rst_n = 1'b0;
    #1 check_all("ar_now", IDLE, 4'd0, 1'b0, 8'd0);
    #1 rst_n = 1'b1;
    tick();
    check_all("ar_after", IDLE, 4'd0, 1'b0, 8'd0);
    tick();
    check_all("ar_idle", IDLE, 4'd0, 1'b0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
